// File: rtl/seq_detect_pkg.sv
// Shared types for seq_detect_arbiter. Holds the detector state encoding,
// the default channel count and the single next-state function that the
// time-shared detector evaluates for whichever channel is granted.
package seq_detect_pkg;

    localparam int unsigned NUM_CH_DEF = 4;
    localparam int unsigned CNT_W      = 8;

    // Moore detector for the overlapping pattern 1101; E is the detect state.
    typedef enum logic [2:0] {
        ST_A = 3'b000,
        ST_B = 3'b010,
        ST_C = 3'b110,
        ST_D = 3'b100,
        ST_E = 3'b011
    } state_e;

    // Next state for one serial bit; unused codes fall back to A.
    function automatic state_e next_state(input logic [2:0] cur, input logic b);
        state_e ns;
        case (cur)
            ST_A:    ns = b ? ST_B : ST_A;
            ST_B:    ns = b ? ST_C : ST_A;
            ST_C:    ns = b ? ST_C : ST_D;
            ST_D:    ns = b ? ST_E : ST_A;
            ST_E:    ns = b ? ST_C : ST_A;
            default: ns = ST_A;
        endcase
        return ns;
    endfunction

endpackage

// File: rtl/seq_detect_arbiter_if.sv
// Bundle of the requester, detection and statistics signals of
// seq_detect_arbiter.
//   master : drives req_valid, req_bit, ch_clr, cnt_sel
//   slave  : drives req_ready (combinational grant), det_valid, det_ch,
//            cur_state, cnt_out
interface seq_detect_arbiter_if
    import seq_detect_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEF
);
    localparam int unsigned IW = $clog2(NUM_CH);

    logic [NUM_CH-1:0] req_valid;
    logic [NUM_CH-1:0] req_bit;
    logic [NUM_CH-1:0] req_ready;
    logic [NUM_CH-1:0] ch_clr;
    logic              det_valid;
    logic [IW-1:0]     det_ch;
    logic [2:0]        cur_state;
    logic [IW-1:0]     cnt_sel;
    logic [CNT_W-1:0]  cnt_out;

    modport master (
        output req_valid, req_bit, ch_clr, cnt_sel,
        input  req_ready, det_valid, det_ch, cur_state, cnt_out
    );

    modport slave (
        input  req_valid, req_bit, ch_clr, cnt_sel,
        output req_ready, det_valid, det_ch, cur_state, cnt_out
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the lowest index >= ptr whose
// request is set and not masked, wrapping modulo N.
//   req   : request vector
//   mask  : channels excluded this cycle
//   ptr   : search start index (always < N)
//   grant : one-hot grant, zero when nothing is eligible
//   idx   : binary index of the granted channel
//   gnt_valid : a grant was issued
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          gnt_valid
);

    logic [N-1:0] elig;
    int unsigned  k;

    assign elig = req & ~mask;

    // Walk N positions starting at ptr; first eligible one wins.
    always_comb begin
        grant     = '0;
        idx       = '0;
        gnt_valid = 1'b0;
        k         = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = 32'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!gnt_valid && elig[IW'(k)]) begin
                grant[IW'(k)] = 1'b1;
                idx           = IW'(k);
                gnt_valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_detect_arbiter.sv
// Time-shared 1101 sequence detector for NUM_CH serial requesters.
// One Moore detector is multiplexed across channels; each channel keeps its
// own 3-bit context. A round-robin arbiter grants one bit per cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : seq_detect_arbiter_if.slave (requests, grant, detection,
//              statistics select/readout)
// Optional: define SEQ_DETECT_ARBITER_STATS_EN for per-channel saturating
// detection counters; otherwise cnt_out reads as zero.
module seq_detect_arbiter
    import seq_detect_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_detect_arbiter_if.slave  bus
);

    localparam int unsigned IW = $clog2(NUM_CH);

    state_e            ctx_q [NUM_CH];
    state_e            ctx_d [NUM_CH];
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              det_valid_q, det_valid_d;
    logic [IW-1:0]     det_ch_q, det_ch_d;
    state_e            cur_state_q, cur_state_d;

    logic [NUM_CH-1:0] req_elig;
    logic [NUM_CH-1:0] grant;
    logic [IW-1:0]     grant_idx;
    logic              grant_any;
    state_e            nxt;

    // Reset holds all requests off so nothing is consumed during rst.
    assign req_elig = bus.req_valid & ~{NUM_CH{rst}};

    rr_arbiter #(.N(NUM_CH)) u_rr (
        .req       (req_elig),
        .mask      (bus.ch_clr),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .idx       (grant_idx),
        .gnt_valid (grant_any)
    );

    assign bus.req_ready = grant;
    assign nxt           = next_state(ctx_q[grant_idx], bus.req_bit[grant_idx]);

    // Next-state: clears first, then the granted channel's update.
    always_comb begin
        ctx_d       = ctx_q;
        rr_ptr_d    = rr_ptr_q;
        det_valid_d = 1'b0;
        det_ch_d    = det_ch_q;
        cur_state_d = cur_state_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (bus.ch_clr[i]) begin
                ctx_d[i] = ST_A;
            end
        end
        if (grant_any) begin
            ctx_d[grant_idx] = nxt;
            rr_ptr_d    = (grant_idx == IW'(NUM_CH - 1)) ? '0 : grant_idx + IW'(1);
            det_valid_d = (nxt == ST_E);
            det_ch_d    = grant_idx;
            cur_state_d = nxt;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                ctx_q[i] <= ST_A;
            end
            rr_ptr_q    <= '0;
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
            cur_state_q <= ST_A;
        end else begin
            ctx_q       <= ctx_d;
            rr_ptr_q    <= rr_ptr_d;
            det_valid_q <= det_valid_d;
            det_ch_q    <= det_ch_d;
            cur_state_q <= cur_state_d;
        end
    end

    assign bus.det_valid = det_valid_q;
    assign bus.det_ch    = det_ch_q;
    assign bus.cur_state = cur_state_q;

`ifdef SEQ_DETECT_ARBITER_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_CH];

    // Per-channel detection counters, saturating; ch_clr wins over a count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (bus.ch_clr[i]) begin
                    cnt_q[i] <= '0;
                end else if (det_valid_q && (det_ch_q == IW'(i)) && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign bus.cnt_out = cnt_q[bus.cnt_sel];
`else
    logic cnt_sel_unused;

    assign cnt_sel_unused = ^bus.cnt_sel;
    assign bus.cnt_out    = '0;
`endif

endmodule

// File: doc/seq_detect_arbiter.md
SEQ_DETECT_ARBITER -- requirements
Module: seq_detect_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of serial requester channels (2..8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  NUM_CH  per-channel serial bit present.
REQ-005 SHALL have port req_bit  input  NUM_CH  per-channel serial data bit.
REQ-006 SHALL have port req_ready  output  NUM_CH  one-hot grant; bit consumed when valid&&ready.
REQ-007 SHALL have port ch_clr  input  NUM_CH  per-channel context clear to state A.
REQ-008 SHALL have port det_valid  output  1  registered detection pulse.
REQ-009 SHALL have port det_ch  output  clog2(NUM_CH)  channel of detection.
REQ-010 SHALL have port cur_state  output  3  post-update state of last granted channel.
REQ-011 SHALL have port cnt_sel  input  clog2(NUM_CH)  statistics channel select.
REQ-012 SHALL have port cnt_out  output  8  detection count of channel cnt_sel.

Function
REQ-013 SHALL time-share one 5-state Moore detector among NUM_CH channels, holding a 3-bit context register per channel.
REQ-014 SHALL encode states A=000, B=010, C=110, D=100, E=011.
REQ-015 SHALL use transitions (bit 0/1): A->A/B, B->A/C, C->D/C, D->A/E, E->A/C; any other code -> A.
REQ-016 SHALL grant at most one channel per cycle, round-robin: lowest index >= rr_ptr with req_valid and not ch_clr, wrapping modulo NUM_CH.
REQ-017 SHALL drive req_ready combinationally from req_valid, ch_clr and rr_ptr; no grant when no eligible request.
REQ-018 SHALL after a grant set rr_ptr to granted index +1 modulo NUM_CH; rr_ptr unchanged on idle cycles.
REQ-019 SHALL on grant write next state into the granted channel context at the same clock edge.
REQ-020 SHALL assert det_valid for exactly one cycle, the cycle after the grant, when the granted channel's next state is E (pattern 1101, overlapping); det_ch and cur_state registered together with it.
REQ-021 SHALL hold det_ch and cur_state unchanged on cycles without a grant; det_valid low.
REQ-022 SHALL on ch_clr[i] set context i to A at the next edge and mask channel i from arbitration that cycle (bit not consumed).
REQ-023 SHALL leave non-granted channel contexts unchanged.

Reset
REQ-024 SHALL on rst set all contexts to A, rr_ptr to 0, det_valid 0, det_ch 0, cur_state 000, counters 0.
REQ-025 SHALL force req_ready to 0 while rst is high; a bit presented during reset is not consumed.
REQ-026 SHALL discard any in-flight detection when rst asserts mid-operation (det_valid 0 next cycle).

Configuration
REQ-027 SHALL with SEQ_DETECT_ARBITER_STATS_EN defined include per-channel 8-bit detection counters, incremented on each det_valid for det_ch, saturating at 255, cleared by rst or ch_clr of that channel; cnt_out combinational mux by cnt_sel.
REQ-028 SHALL without SEQ_DETECT_ARBITER_STATS_EN keep ports cnt_sel/cnt_out, tie cnt_out to 0 and instantiate no counters.

Structure
REQ-029 SHALL place state typedef, the five encodings, and NUM_CH default in shared package seq_detect_pkg.
REQ-030 SHALL implement round-robin grant in sub-module rr_arbiter (req, mask, ptr in; one-hot grant, index out).
REQ-031 SHALL implement the next-state function as a function in seq_detect_pkg, not duplicated.

Verification
REQ-032 SHALL test: ch0 only, bits 1,1,0,1 -> det_valid=1, det_ch=0, cur_state=011 one cycle after 4th grant.
REQ-033 SHALL test: all 4 channels valid every cycle -> grants 0,1,2,3,0 in order; each req_ready one-hot.
REQ-034 SHALL test: ch1 bits 1,1,0 then ch_clr[1] with valid high -> ready[1]=0, context A; next 1 -> state 010, no detection.
REQ-035 SHALL test: ch2 bits 1,1,0,1,1,0,1 -> two detections (overlap); with STATS_EN cnt_sel=2 gives cnt_out=2.
REQ-036 SHALL test: rst asserted during grant of 4th bit of 1101 -> det_valid stays 0, rr_ptr=0, all contexts 000.
REQ-037 SHALL test: STATS_EN, 260 detections on ch3 -> cnt_out=255 saturated.
